// File: rtl/gpu_noc_port_if.sv
// ---------------------------------------------------------------------------
// gpu_noc_port_if
// Bundles the GPU-facing and router-facing flit links of one NoC port.
// Flit format on every 16-bit flit signal: [15:10] dest node ID, [9:0] payload.
//
// Signals:
//   gpu_tx_data/valid/ready : GPU -> port flit stream (valid/ready)
//   gpu_rx_data/valid/ready : port -> GPU flit stream (first-word-fall-through)
//   rt_flit_out/valid_out   : port -> router flit strobe
//   rt_credit_in            : credits the router returns to this port (0..3)
//   rt_flit_in/valid_in     : router -> port flit strobe
//   rt_credit_out           : credits this port returns to the router (0..2)
//
// Modports:
//   slave  : view taken by the port itself
//   master : view taken by the environment (GPU node plus router link)
// ---------------------------------------------------------------------------
interface gpu_noc_port_if;
    logic [15:0] gpu_tx_data;
    logic        gpu_tx_valid;
    logic        gpu_tx_ready;
    logic [15:0] gpu_rx_data;
    logic        gpu_rx_valid;
    logic        gpu_rx_ready;
    logic [15:0] rt_flit_out;
    logic        rt_valid_out;
    logic [1:0]  rt_credit_in;
    logic [15:0] rt_flit_in;
    logic        rt_valid_in;
    logic [1:0]  rt_credit_out;

    modport slave (
        input  gpu_tx_data, gpu_tx_valid,
        output gpu_tx_ready,
        output gpu_rx_data, gpu_rx_valid,
        input  gpu_rx_ready,
        output rt_flit_out, rt_valid_out,
        input  rt_credit_in,
        input  rt_flit_in, rt_valid_in,
        output rt_credit_out
    );

    modport master (
        output gpu_tx_data, gpu_tx_valid,
        input  gpu_tx_ready,
        input  gpu_rx_data, gpu_rx_valid,
        output gpu_rx_ready,
        input  rt_flit_out, rt_valid_out,
        output rt_credit_in,
        output rt_flit_in, rt_valid_in,
        input  rt_credit_out
    );
endinterface

// File: rtl/gpu_noc_port.sv
// ---------------------------------------------------------------------------
// gpu_noc_port
// Network-side adapter between one GPU node and a mesh router link.
//   TX: GPU flits are buffered and forwarded to the router under
//       credit-based flow control (one flit per cycle while credit lasts).
//   RX: router flits are filtered by destination ID, buffered, and shown
//       to the GPU first-word-fall-through. Every slot freed and every
//       misrouted flit dropped is returned to the router as a credit.
//
// Ports:
//   ACLK          : clock
//   ARESETn       : asynchronous active-low reset
//   bus           : gpu_noc_port_if.slave, GPU and router flit links
//   misroute_cnt  : saturating count of flits dropped as misrouted
//   credit_err    : sticky, router returned more credits than the maximum
//   rx_ovf_err    : sticky, a flit for this node arrived with the RX FIFO full
// ---------------------------------------------------------------------------
module gpu_noc_port #(
    parameter logic [5:0] NODE_ID  = 6'd5,
    parameter logic [5:0] BCAST_ID = 6'h3F,
    parameter int         TX_DEPTH = 4,
    parameter int         RX_DEPTH = 4,
    parameter int         CREDITS  = 4
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    gpu_noc_port_if.slave bus,
    output logic [7:0]    misroute_cnt,
    output logic          credit_err,
    output logic          rx_ovf_err
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int CRW   = $clog2(CREDITS + 1);
    // Wide enough for credit plus the largest return (3) without wrapping.
    localparam int SUMW  = CRW + 2;

    localparam logic [TX_AW:0]  TX_FULL    = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0]  RX_FULL    = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [CRW-1:0]  CREDIT_MAX = CRW'(CREDITS);
    localparam logic [SUMW-1:0] CREDIT_LIM = SUMW'(CREDITS);

    // ------------------------------------------------------------------
    // TX path state
    // ------------------------------------------------------------------
    logic [15:0]      tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_q, tx_rd_q;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic             tx_push, tx_pop;
    logic [15:0]      rt_flit_q;
    logic             rt_valid_q;

    logic [CRW-1:0]   credit_q, credit_d;
    logic [SUMW-1:0]  credit_sum;
    logic             credit_ovf;
    logic             credit_err_q;

    // ------------------------------------------------------------------
    // RX path state
    // ------------------------------------------------------------------
    logic [15:0]      rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_q, rx_rd_q;
    logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
    logic [5:0]       rx_dest;
    logic             rx_match, rx_full;
    logic             rx_push, rx_pop, rx_drop_ovf, rx_misroute;
    logic [1:0]       credit_out_q, credit_out_d;
    logic [7:0]       misroute_cnt_q;
    logic             rx_ovf_err_q;

    // ------------------------------------------------------------------
    // TX handshake. Ready comes from the registered count only, so a
    // pop on a full FIFO does not open a slot until the next cycle.
    // ------------------------------------------------------------------
    assign bus.gpu_tx_ready = (tx_cnt_q != TX_FULL);
    assign tx_push          = bus.gpu_tx_valid && bus.gpu_tx_ready;
    assign tx_pop           = (tx_cnt_q != '0) && (credit_q != '0);

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        unique case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (TX_AW + 1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TX_AW + 1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // Credit bookkeeping: the sum never goes negative because a send
    // needs a credit in hand. Anything above the maximum is a router
    // protocol error; keep the maximum and flag it.
    always_comb begin
        credit_sum = SUMW'(credit_q) - SUMW'(tx_pop) + SUMW'(bus.rt_credit_in);
        credit_ovf = (credit_sum > CREDIT_LIM);
        credit_d   = credit_ovf ? CREDIT_MAX : credit_sum[CRW-1:0];
    end

    // TX storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge ACLK) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q] <= bus.gpu_tx_data;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_cnt_q     <= '0;
            rt_flit_q    <= '0;
            rt_valid_q   <= 1'b0;
            credit_q     <= CREDIT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            credit_q   <= credit_d;
            rt_valid_q <= tx_pop;
            if (tx_push) begin
                tx_wr_q <= tx_wr_q + TX_AW'(1);
            end
            // The outgoing flit register holds its last value between strobes.
            if (tx_pop) begin
                rt_flit_q <= tx_mem_q[tx_rd_q];
                tx_rd_q   <= tx_rd_q + TX_AW'(1);
            end
            if (credit_ovf) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX classification. Full is judged on the pre-edge count, so a flit
    // arriving while the GPU pops a full FIFO is still an overflow.
    // ------------------------------------------------------------------
    assign rx_dest     = bus.rt_flit_in[15:10];
    assign rx_match    = (rx_dest == NODE_ID) || (rx_dest == BCAST_ID);
    assign rx_full     = (rx_cnt_q == RX_FULL);
    assign rx_push     = bus.rt_valid_in && rx_match && !rx_full;
    assign rx_drop_ovf = bus.rt_valid_in && rx_match && rx_full;
    assign rx_misroute = bus.rt_valid_in && !rx_match;
    assign rx_pop      = (rx_cnt_q != '0) && bus.gpu_rx_ready;

    assign bus.gpu_rx_valid = (rx_cnt_q != '0);
    assign bus.gpu_rx_data  = rx_mem_q[rx_rd_q];

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (RX_AW + 1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RX_AW + 1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // A freed RX slot and a dropped misroute each hand a credit back;
    // an overflow drop returns nothing since the router sent without one.
    assign credit_out_d = {1'b0, rx_pop} + {1'b0, rx_misroute};

    always_ff @(posedge ACLK) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_q] <= bus.rt_flit_in;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_wr_q        <= '0;
            rx_rd_q        <= '0;
            rx_cnt_q       <= '0;
            credit_out_q   <= '0;
            misroute_cnt_q <= '0;
            rx_ovf_err_q   <= 1'b0;
        end else begin
            rx_cnt_q     <= rx_cnt_d;
            credit_out_q <= credit_out_d;
            if (rx_push) begin
                rx_wr_q <= rx_wr_q + RX_AW'(1);
            end
            if (rx_pop) begin
                rx_rd_q <= rx_rd_q + RX_AW'(1);
            end
            if (rx_misroute && (misroute_cnt_q != 8'hFF)) begin
                misroute_cnt_q <= misroute_cnt_q + 8'd1;
            end
            if (rx_drop_ovf) begin
                rx_ovf_err_q <= 1'b1;
            end
        end
    end

    assign bus.rt_flit_out   = rt_flit_q;
    assign bus.rt_valid_out  = rt_valid_q;
    assign bus.rt_credit_out = credit_out_q;
    assign misroute_cnt      = misroute_cnt_q;
    assign credit_err        = credit_err_q;
    assign rx_ovf_err        = rx_ovf_err_q;

endmodule

// File: tb/tb_gpu_noc_port.sv
// ---------------------------------------------------------------------------
// tb_gpu_noc_port
// Self-checking bench for gpu_noc_port. Directed steps walk through reset,
// single send, credit exhaustion and clamping, TX full, RX filtering and RX
// overflow; randomized traffic then runs against a queue-based model of the
// port. Every cycle the model's view of all outputs is compared with the DUT.
// ---------------------------------------------------------------------------
module tb_gpu_noc_port;

    localparam logic [5:0] NODE_ID  = 6'd5;
    localparam logic [5:0] BCAST_ID = 6'h3F;
    localparam int         TX_DEPTH = 4;
    localparam int         RX_DEPTH = 4;
    localparam int         CREDITS  = 4;

    logic       ACLK    = 1'b0;
    logic       ARESETn = 1'b1;
    logic [7:0] misroute_cnt;
    logic       credit_err;
    logic       rx_ovf_err;

    int testsRun    = 0;
    int testsFailed = 0;

    gpu_noc_port_if bus ();

    gpu_noc_port #(
        .NODE_ID  (NODE_ID),
        .BCAST_ID (BCAST_ID),
        .TX_DEPTH (TX_DEPTH),
        .RX_DEPTH (RX_DEPTH),
        .CREDITS  (CREDITS)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .bus          (bus),
        .misroute_cnt (misroute_cnt),
        .credit_err   (credit_err),
        .rx_ovf_err   (rx_ovf_err)
    );

    // Free-running clock, 10 time units per period.
    always #5 ACLK = ~ACLK;

    // Reference model: two bounded queues, a credit integer and the
    // registered outputs as the port should present them.
    logic [15:0] mTxQ[$];
    logic [15:0] mRxQ[$];
    int          mCredit;
    int          mMisroute;
    bit          mCreditErr;
    bit          mOvfErr;
    bit          mValidOut;
    logic [15:0] mFlitOut;
    logic [1:0]  mCreditOut;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mTxQ.delete();
        mRxQ.delete();
        mCredit    = CREDITS;
        mMisroute  = 0;
        mCreditErr = 1'b0;
        mOvfErr    = 1'b0;
        mValidOut  = 1'b0;
        mFlitOut   = 16'h0000;
        mCreditOut = 2'd0;
    endtask

    // One clock edge of the port's behaviour, decided from pre-edge state.
    task automatic modelStep(input logic txv, input logic [15:0] txd, input logic [1:0] crin,
                             input logic rxv, input logic [15:0] rxd, input logic rxr);
        bit         txAcc, send, rxPop, rxWasFull, forUs, misrouted;
        int         nextCredit;
        logic [5:0] dest;
        dest      = rxd[15:10];
        txAcc     = txv && (mTxQ.size() < TX_DEPTH);
        send      = (mTxQ.size() > 0) && (mCredit > 0);
        rxPop     = rxr && (mRxQ.size() > 0);
        rxWasFull = (mRxQ.size() >= RX_DEPTH);
        forUs     = (dest == NODE_ID) || (dest == BCAST_ID);
        misrouted = rxv && !forUs;

        if (send) mFlitOut = mTxQ.pop_front();
        mValidOut = send;
        if (txAcc) mTxQ.push_back(txd);

        nextCredit = mCredit - int'(send) + int'(crin);
        if (nextCredit > CREDITS) begin
            mCredit    = CREDITS;
            mCreditErr = 1'b1;
        end else begin
            mCredit = nextCredit;
        end

        if (rxPop) void'(mRxQ.pop_front());
        if (rxv && forUs) begin
            if (rxWasFull) mOvfErr = 1'b1;
            else mRxQ.push_back(rxd);
        end
        if (misrouted && (mMisroute < 255)) mMisroute++;
        mCreditOut = 2'(int'(rxPop) + int'(misrouted));
    endtask

    task automatic checkModel();
        checkOutput("rt_valid_out", 32'(bus.rt_valid_out), 32'(mValidOut));
        checkOutput("rt_flit_out", 32'(bus.rt_flit_out), 32'(mFlitOut));
        checkOutput("gpu_tx_ready", 32'(bus.gpu_tx_ready), 32'(mTxQ.size() < TX_DEPTH));
        checkOutput("gpu_rx_valid", 32'(bus.gpu_rx_valid), 32'(mRxQ.size() > 0));
        if (mRxQ.size() > 0) checkOutput("gpu_rx_data", 32'(bus.gpu_rx_data), 32'(mRxQ[0]));
        checkOutput("rt_credit_out", 32'(bus.rt_credit_out), 32'(mCreditOut));
        checkOutput("misroute_cnt", 32'(misroute_cnt), 32'(mMisroute));
        checkOutput("credit_err", 32'(credit_err), 32'(mCreditErr));
        checkOutput("rx_ovf_err", 32'(rx_ovf_err), 32'(mOvfErr));
    endtask

    // Drive one cycle of inputs, advance past the edge, check against model.
    task automatic applyStimulus(input logic txv, input logic [15:0] txd, input logic [1:0] crin,
                                 input logic rxv, input logic [15:0] rxd, input logic rxr);
        bus.gpu_tx_valid = txv;
        bus.gpu_tx_data  = txd;
        bus.rt_credit_in = crin;
        bus.rt_valid_in  = rxv;
        bus.rt_flit_in   = rxd;
        bus.gpu_rx_ready = rxr;
        @(posedge ACLK);
        modelStep(txv, txd, crin, rxv, rxd, rxr);
        #1;
        checkModel();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic resetDut();
        bus.gpu_tx_valid = 1'b0;
        bus.gpu_tx_data  = 16'h0;
        bus.rt_credit_in = 2'd0;
        bus.rt_valid_in  = 1'b0;
        bus.rt_flit_in   = 16'h0;
        bus.gpu_rx_ready = 1'b0;
        ARESETn = 1'b0;
        #2;
        checkOutput("rst_rt_valid_out", 32'(bus.rt_valid_out), 32'd0);
        checkOutput("rst_rt_flit_out", 32'(bus.rt_flit_out), 32'd0);
        checkOutput("rst_rt_credit_out", 32'(bus.rt_credit_out), 32'd0);
        checkOutput("rst_misroute_cnt", 32'(misroute_cnt), 32'd0);
        checkOutput("rst_credit_err", 32'(credit_err), 32'd0);
        checkOutput("rst_rx_ovf_err", 32'(rx_ovf_err), 32'd0);
        checkOutput("rst_gpu_rx_valid", 32'(bus.gpu_rx_valid), 32'd0);
        modelReset();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        checkOutput("rst_gpu_tx_ready", 32'(bus.gpu_tx_ready), 32'd1);
    endtask

    task automatic randomTraffic(input int n);
        logic        txv, rxv, rxr;
        logic [15:0] txd, rxd;
        logic [1:0]  crin;
        logic [5:0]  dest;
        for (int i = 0; i < n; i++) begin
            txv  = 1'($urandom_range(0, 1));
            txd  = 16'($urandom);
            crin = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            rxv  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       dest = NODE_ID;
                1:       dest = BCAST_ID;
                default: dest = 6'($urandom_range(6, 62));
            endcase
            rxd = {dest, 10'($urandom)};
            rxr = ($urandom_range(0, 2) != 0);
            applyStimulus(txv, txd, crin, rxv, rxd, rxr);
        end
    endtask

    // Bound the whole run so a stuck simulation still reports.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          strobes;
        logic [15:0] seen[$];

        #1;
        resetDut();

        // Single TX: push at edge E, one strobe from E+1, then quiet.
        applyStimulus(1'b1, 16'h1923, 2'd0, 1'b0, 16'h0, 1'b0);
        checkOutput("single_not_yet", 32'(bus.rt_valid_out), 32'd0);
        idleCycles(1);
        checkOutput("single_valid", 32'(bus.rt_valid_out), 32'd1);
        checkOutput("single_flit", 32'(bus.rt_flit_out), 32'h1923);
        idleCycles(1);
        checkOutput("single_done", 32'(bus.rt_valid_out), 32'd0);
        applyStimulus(1'b0, 16'h0, 2'd1, 1'b0, 16'h0, 1'b0);

        // Credit exhaustion: six pushes with no returns give four strobes.
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i < 6, 16'h0400 + 16'(i), 2'd0, 1'b0, 16'h0, 1'b0);
            if (bus.rt_valid_out) strobes++;
        end
        checkOutput("exhaust_strobes", 32'(strobes), 32'd4);
        applyStimulus(1'b0, 16'h0, 2'd1, 1'b0, 16'h0, 1'b0);
        checkOutput("one_credit_wait", 32'(bus.rt_valid_out), 32'd0);
        idleCycles(1);
        checkOutput("fifth_valid", 32'(bus.rt_valid_out), 32'd1);
        checkOutput("fifth_flit", 32'(bus.rt_flit_out), 32'h0404);
        applyStimulus(1'b0, 16'h0, 2'd3, 1'b0, 16'h0, 1'b0);
        checkOutput("credit_err_low", 32'(credit_err), 32'd0);
        idleCycles(1);
        checkOutput("sixth_flit", 32'(bus.rt_flit_out), 32'h0405);
        applyStimulus(1'b0, 16'h0, 2'd1, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 16'h0, 2'd3, 1'b0, 16'h0, 1'b0);
        checkOutput("credit_err_set", 32'(credit_err), 32'd1);

        // Clamped credit is exactly four: five pushes, four strobes.
        strobes = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i < 5, 16'h0500 + 16'(i), 2'd0, 1'b0, 16'h0, 1'b0);
            if (bus.rt_valid_out) strobes++;
        end
        checkOutput("clamp_strobes", 32'(strobes), 32'd4);
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0, (i == 0) ? 2'd1 : 2'd0, 1'b0, 16'h0, 1'b0);
            if (bus.rt_valid_out) strobes++;
        end
        checkOutput("drain_strobes", 32'(strobes), 32'd1);
        checkOutput("drain_flit", 32'(bus.rt_flit_out), 32'h0504);

        // TX full with zero credit: ready drops after exactly four accepts.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0800 + 16'(i), 2'd0, 1'b0, 16'h0, 1'b0);
            checkOutput($sformatf("txfull_ready_%0d", i), 32'(bus.gpu_tx_ready), 32'(i < 3));
        end
        idleCycles(0);
        applyStimulus(1'b1, 16'h0804, 2'd0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h0804, 2'd0, 1'b0, 16'h0, 1'b0);
        checkOutput("txfull_hold_ready", 32'(bus.gpu_tx_ready), 32'd0);
        applyStimulus(1'b1, 16'h0804, 2'd1, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h0804, 2'd0, 1'b0, 16'h0, 1'b0);
        checkOutput("txfull_first_out", 32'(bus.rt_flit_out), 32'h0800);
        applyStimulus(1'b1, 16'h0804, 2'd0, 1'b0, 16'h0, 1'b0);
        seen.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 16'h0, (i < 5) ? 2'd1 : 2'd0, 1'b0, 16'h0, 1'b0);
            if (bus.rt_valid_out) seen.push_back(bus.rt_flit_out);
        end
        checkOutput("txfull_drain_cnt", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            checkOutput("txfull_drain_first", 32'(seen[0]), 32'h0801);
            checkOutput("txfull_held_flit", 32'(seen[3]), 32'h0804);
        end

        // RX filtering for node 5.
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b1, 16'h1555, 1'b0);
        checkOutput("rx_own_valid", 32'(bus.gpu_rx_valid), 32'd1);
        checkOutput("rx_own_data", 32'(bus.gpu_rx_data), 32'h1555);
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b1, 16'h1955, 1'b0);
        checkOutput("rx_mis_cnt", 32'(misroute_cnt), 32'd1);
        checkOutput("rx_mis_credit", 32'(bus.rt_credit_out), 32'd1);
        checkOutput("rx_mis_head", 32'(bus.gpu_rx_data), 32'h1555);
        idleCycles(1);
        checkOutput("rx_credit_idle", 32'(bus.rt_credit_out), 32'd0);
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b1, 16'hFC01, 1'b0);
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1);
        checkOutput("rx_bcast_data", 32'(bus.gpu_rx_data), 32'hFC01);
        checkOutput("rx_pop_credit", 32'(bus.rt_credit_out), 32'd1);

        // Pop and misroute in one cycle return two credits.
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b1, 16'h1955, 1'b1);
        checkOutput("dual_credit", 32'(bus.rt_credit_out), 32'd2);
        checkOutput("dual_rx_empty", 32'(bus.gpu_rx_valid), 32'd0);

        // RX overflow leaves the stored flits untouched.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 2'd0, 1'b1, 16'h1401 + 16'(i), 1'b0);
        checkOutput("ovf_not_yet", 32'(rx_ovf_err), 32'd0);
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b1, 16'h1405, 1'b0);
        checkOutput("ovf_set", 32'(rx_ovf_err), 32'd1);
        checkOutput("ovf_no_credit", 32'(bus.rt_credit_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf_keep_%0d", i), 32'(bus.gpu_rx_data), 32'h1401 + 32'(i));
            applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1);
        end
        checkOutput("ovf_drained", 32'(bus.gpu_rx_valid), 32'd0);

        // Random traffic, then a reset in the middle of it.
        randomTraffic(150);
        resetDut();
        strobes = 0;
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i < 4, 16'h0C00 + 16'(i), 2'd0, 1'b0, 16'h0, 1'b0);
            if (bus.rt_valid_out) seen.push_back(bus.rt_flit_out);
            if (i > 0 && bus.rt_valid_out) strobes++;
        end
        checkOutput("post_rst_strobes", 32'(strobes), 32'd4);
        if (seen.size() > 0) checkOutput("post_rst_first", 32'(seen[0]), 32'h0C00);
        randomTraffic(250);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
